alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_core.sv | 68 ++++++
 rtl/alu_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq block: opcode enum, FSM state
// enum and the opcode constants the controller uses to decode shifts.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOTB = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_SRA  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    localparam logic [2:0] OPC_SHL = 3'b110;
    localparam logic [2:0] OPC_SRA = 3'b111;

endpackage

// File: rtl/alu_seq_core.sv
// Combinational W-bit compute for the non-shift ops plus N/V/Z flag
// derivation. With ALU_CARRY_EN defined it also produces the carry flag
// (carry out for ADD, not-borrow for SUB, 0 otherwise).
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int W = 16
)
(
    input  alu_op_e        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   r,
    output logic           n,
    output logic           v,
    output logic           z
`ifdef ALU_CARRY_EN
    ,
    output logic           c
`endif
);

    // One extra bit on the adder only when the carry flag is built.
`ifdef ALU_CARRY_EN
    localparam int EW = W + 1;
`else
    localparam int EW = W;
`endif

    logic [EW-1:0] sum_ext;
    logic [EW-1:0] dif_ext;

    assign sum_ext = EW'(a) + EW'(b);
    assign dif_ext = EW'(a) - EW'(b);

    // Operation select, overflow and carry derivation.
    always_comb begin
        r = '0;
        v = 1'b0;
`ifdef ALU_CARRY_EN
        c = 1'b0;
`endif
        case (op)
            OP_ADD: begin
                r = sum_ext[W-1:0];
                v = (a[W-1] == b[W-1]) && (sum_ext[W-1] != a[W-1]);
`ifdef ALU_CARRY_EN
                c = sum_ext[EW-1];
`endif
            end
            OP_SUB: begin
                r = dif_ext[W-1:0];
                v = (a[W-1] != b[W-1]) && (dif_ext[W-1] != a[W-1]);
`ifdef ALU_CARRY_EN
                c = ~dif_ext[EW-1];
`endif
            end
            OP_AND:  r = a & b;
            OP_NOTB: r = ~b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        n = r[W-1];
        z = (r == '0);
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with iterative one-bit-per-cycle shifts and a
// status register (n/v/z) that loads only when load_status was set on the
// accepted op. Optional carry flag c is built when ALU_CARRY_EN is defined.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W  = 16,
    parameter int SW = $clog2(W)
)
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [SW-1:0]  shamt,
    input  logic           load_status,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   result,
    output logic           n,
    output logic           v,
    output logic           z
`ifdef ALU_CARRY_EN
    ,
    output logic           c
`endif
);

    alu_state_e     state_q, state_d;
    logic [W-1:0]   res_q,   res_d;
    logic [SW-1:0]  cnt_q,   cnt_d;
    logic           sra_q,   sra_d;
    logic           ls_q,    ls_d;
    logic           n_q,     n_d;
    logic           v_q,     v_d;
    logic           z_q,     z_d;
`ifdef ALU_CARRY_EN
    logic           c_q,     c_d;
    logic           core_c;
    logic           sh_out;
`endif

    logic [W-1:0]   core_r;
    logic           core_n;
    logic           core_v;
    logic           core_z;
    logic [W-1:0]   sh_next;
    logic           is_shift;

    alu_seq_core #(.W(W)) u_core (
        .op (alu_op_e'(op)),
        .a  (a),
        .b  (b),
        .r  (core_r),
        .n  (core_n),
        .v  (core_v),
        .z  (core_z)
`ifdef ALU_CARRY_EN
        ,
        .c  (core_c)
`endif
    );

    assign is_shift = (op == OPC_SHL) || (op == OPC_SRA);

    // One-bit shift step of the working register (and the bit it drops).
    always_comb begin
        if (sra_q) begin
            sh_next = {res_q[W-1], res_q[W-1:1]};
        end else begin
            sh_next = {res_q[W-2:0], 1'b0};
        end
`ifdef ALU_CARRY_EN
        sh_out = sra_q ? res_q[0] : res_q[W-1];
`endif
    end

    // Next-state, datapath and status-register update.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sra_d   = sra_q;
        ls_d    = ls_q;
        n_d     = n_q;
        v_d     = v_q;
        z_d     = z_q;
`ifdef ALU_CARRY_EN
        c_d     = c_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sra_d = (op == OPC_SRA);
                    ls_d  = load_status;
                    if (is_shift) begin
                        res_d = a;
                        cnt_d = shamt;
                        if (shamt == '0) begin
                            // Zero-length shift completes immediately with result=a.
                            state_d = ST_DONE;
                            if (load_status) begin
                                n_d = a[W-1];
                                v_d = 1'b0;
                                z_d = (a == '0);
`ifdef ALU_CARRY_EN
                                c_d = 1'b0;
`endif
                            end
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        res_d   = core_r;
                        state_d = ST_DONE;
                        if (load_status) begin
                            n_d = core_n;
                            v_d = core_v;
                            z_d = core_z;
`ifdef ALU_CARRY_EN
                            c_d = core_c;
`endif
                        end
                    end
                end
            end
            ST_SHIFT: begin
                res_d = sh_next;
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    state_d = ST_DONE;
                    if (ls_q) begin
                        n_d = sh_next[W-1];
                        v_d = 1'b0;
                        z_d = (sh_next == '0);
`ifdef ALU_CARRY_EN
                        c_d = sh_out;
`endif
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; async reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            cnt_q   <= '0;
            sra_q   <= 1'b0;
            ls_q    <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
`ifdef ALU_CARRY_EN
            c_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sra_q   <= sra_d;
            ls_q    <= ls_d;
            n_q     <= n_d;
            v_q     <= v_d;
            z_q     <= z_d;
`ifdef ALU_CARRY_EN
            c_q     <= c_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = res_q;
    assign n         = n_q;
    assign v         = v_q;
    assign z         = z_q;
`ifdef ALU_CARRY_EN
    assign c         = c_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=16) with an expected-result queue.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  shamt;
    logic        load_status;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        n;
    logic        v;
    logic        z;
`ifdef ALU_CARRY_EN
    logic        c;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] res;
        logic        n;
        logic        v;
        logic        z;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .shamt       (shamt),
        .load_status (load_status),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .n           (n),
        .v           (v),
        .z           (z)
`ifdef ALU_CARRY_EN
        ,
        .c           (c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for out_valid (bounded), compare against the queue head, consume.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [15:0] aa,
                         input logic [15:0] bb, input logic [3:0] sa, input logic ls,
                         input logic [15:0] er, input logic en, input logic ev,
                         input logic ez, input int elat);
        exp_t e;
        int   lat;
        @(negedge clk);
        chk({tag, "_in_ready_pre"}, in_ready, 1);
        op = o; a = aa; b = bb; shamt = sa; load_status = ls; in_valid = 1'b1;
        e.res = er; e.n = en; e.v = ev; e.z = ez; e.lat = elat;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, lat, e.lat);
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_nvz"}, {n, v, z}, {e.n, e.v, e.z});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle_after"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        exp_t e;
        int   seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'b000; a = '0; b = '0; shamt = '0; load_status = 1'b0;
        #12;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_nvz", {n, v, z}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add",     3'b000, 16'd13,   16'd10,   4'd0,  1'b1, 16'h0017, 1'b0, 1'b0, 1'b0, 0);
        do_op("sub_neg", 3'b001, 16'hFFFD, 16'd10,   4'd0,  1'b1, 16'hFFF3, 1'b1, 1'b0, 1'b0, 0);
        do_op("notb",    3'b011, 16'h0000, 16'd10,   4'd0,  1'b1, 16'hFFF5, 1'b1, 1'b0, 1'b0, 0);
        do_op("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 4'd0,  1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 0);
        do_op("and_nols",3'b010, 16'h0005, 16'h0002, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 0);
        do_op("sra15",   3'b111, 16'h8000, 16'h1234, 4'd15, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 15);
        do_op("shl0",    3'b110, 16'h0003, 16'h5555, 4'd0,  1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 0);
        do_op("or",      3'b100, 16'h00F0, 16'h0F0F, 4'd0,  1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b0, 0);
        do_op("xor_z",   3'b101, 16'hAAAA, 16'hAAAA, 4'd0,  1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        do_op("sub_ovf", 3'b001, 16'h8000, 16'h0001, 4'd0,  1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 0);
        do_op("shl4",    3'b110, 16'h0003, 16'h0000, 4'd4,  1'b1, 16'h0030, 1'b0, 1'b0, 1'b0, 4);

        // Backpressure: hold DONE while in_valid toggles with a different op.
        @(negedge clk);
        op = 3'b000; a = 16'd1; b = 16'd1; shamt = '0; load_status = 1'b0; in_valid = 1'b1;
        e.res = 16'h0002; e.n = 1'b0; e.v = 1'b0; e.z = 1'b0; e.lat = 0;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = sb.pop_front();
        chk("bp_out_valid", out_valid, 1);
        chk("bp_result", result, e.res);
        chk("bp_nvz", {n, v, z}, {e.n, e.v, e.z});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            op = 3'b100; a = 16'hFFFF; b = 16'h00FF;
            @(posedge clk); #1;
            chk("bp_hold_result", result, e.res);
            chk("bp_hold_ready", {in_ready, out_valid}, 2'b01);
        end
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_release", {in_ready, out_valid}, 2'b10);
        chk("bp_release_result", result, e.res);
        @(posedge clk); #1;
        chk("bp_no_accept", {in_ready, out_valid}, 2'b10);

        // Reset in the middle of a 10-step shift.
        @(negedge clk);
        op = 3'b110; a = 16'h0001; b = '0; shamt = 4'd10; load_status = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_nvz", {n, v, z}, 3'b000);
        chk("rst_in_ready_low", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready_after", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rst_discarded", seen, 0);

        do_op("add_post_rst", 3'b000, 16'd2, 16'd3, 4'd0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
